// File: rtl/serial_subtr.sv
// Bit-serial subtractor: a - b - bin over WIDTH cycles, LSB first, using one
// full-subtractor cell and a registered borrow. start/busy/done host handshake.
module serial_subtr #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;

   logic             d_bit;
   logic             br_next;
   logic             last;

   // Single full-subtractor cell; operands shift right so bit[count] is always at [0].
   assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
   assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
   assign last    = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      br_d     = br_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
               state_d = StRun;
            end else begin
               state_d = StIdle;
            end
         end
         StRun: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = {d_bit, res_q[WIDTH-1:1]};
            br_d  = br_next;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               // br_q here is the borrow into the MSB cell.
               diff_d   = {d_bit, res_q[WIDTH-1:1]};
               borrow_d = br_next;
               ovf_d    = br_q ^ br_next;
               cnt_d    = '0;
               state_d  = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         br_q     <= 1'b0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         br_q     <= br_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy   = (state_q == StRun);
   assign done   = (state_q == StDone);
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtr.sv
// Scoreboard bench for serial_subtr: WIDTH=8 directed/random ops plus an
// exhaustive WIDTH=2 sweep, checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_subtr;

   typedef struct {
      int diff;
      int borrow;
      int ovf;
      int acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0, bin8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, borrow8, ovf8;
   logic [7:0] diff8;
   logic       start2 = 1'b0, bin2 = 1'b0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       busy2, done2, borrow2, ovf2;
   logic [1:0] diff2;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   exp_t q8[$];
   exp_t q2[$];

   serial_subtr #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
   );

   serial_subtr #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
      .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2), .ovf(ovf2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow.
   function automatic exp_t model(input int w, input int a, input int b, input int bin,
                                  input int acc);
      exp_t e;
      int   u, sa, sb, s, half;
      half     = 1 << (w - 1);
      u        = a - b - bin;
      sa       = (a >= half) ? a - (1 << w) : a;
      sb       = (b >= half) ? b - (1 << w) : b;
      s        = sa - sb - bin;
      e.diff   = u & ((1 << w) - 1);
      e.borrow = (u < 0) ? 1 : 0;
      e.ovf    = (s < -half || s > half - 1) ? 1 : 0;
      e.acc    = acc;
      return e;
   endfunction

   // Monitors: pop an expectation on every done pulse.
   always @(negedge clk) begin
      if (done8) begin
         if (q8.size() == 0) begin
            chk("w8_spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = q8.pop_front();
            chk("w8_diff", int'(diff8), e.diff);
            chk("w8_borrow", int'(borrow8), e.borrow);
            chk("w8_ovf", int'(ovf8), e.ovf);
            chk("w8_latency", cyc - e.acc, 8);
         end
      end
   end

   always @(negedge clk) begin
      if (done2) begin
         if (q2.size() == 0) begin
            chk("w2_spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = q2.pop_front();
            chk("w2_diff", int'(diff2), e.diff);
            chk("w2_borrow", int'(borrow2), e.borrow);
            chk("w2_ovf", int'(ovf2), e.ovf);
            chk("w2_latency", cyc - e.acc, 2);
         end
      end
   end

   task automatic accept8(input int a, input int b, input int bin, input bit hold);
      @(negedge clk);
      start8 = 1'b1;
      a8     = 8'(a);
      b8     = 8'(b);
      bin8   = 1'(bin);
      @(posedge clk);
      #1;
      q8.push_back(model(8, a, b, bin, cyc));
      start8 = hold;
      // Scramble inputs: the DUT must have captured them already.
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      bin8   = 1'($urandom);
   endtask

   task automatic wait8(input int exp_busy);
      int n = 0;
      bit got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done8) begin
            got = 1'b1;
            break;
         end
         if (busy8) n++;
      end
      chk("w8_done_seen", int'(got), 1);
      chk("w8_busy_cycles", n, exp_busy);
   endtask

   task automatic op2(input int a, input int b, input int bin);
      bit got = 1'b0;
      @(negedge clk);
      start2 = 1'b1;
      a2     = 2'(a);
      b2     = 2'(b);
      bin2   = 1'(bin);
      @(posedge clk);
      #1;
      q2.push_back(model(2, a, b, bin, cyc));
      start2 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done2) begin
            got = 1'b1;
            break;
         end
      end
      chk("w2_done_seen", int'(got), 1);
   endtask

   initial begin
      #1;
      chk("rst_busy", int'(busy8), 0);
      chk("rst_done", int'(done8), 0);
      chk("rst_diff", int'(diff8), 0);
      chk("rst_borrow", int'(borrow8), 0);
      chk("rst_ovf", int'(ovf8), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      accept8(8'h05, 8'h03, 0, 1'b0); wait8(8);
      accept8(8'h03, 8'h05, 0, 1'b0); wait8(8);
      accept8(8'h80, 8'h01, 0, 1'b0); wait8(8);
      accept8(8'h00, 8'h00, 1, 1'b0); wait8(8);

      // start during RUN is ignored
      accept8(8'h09, 8'h04, 0, 1'b0);
      repeat (3) @(negedge clk);
      start8 = 1'b1;
      a8     = 8'h10;
      b8     = 8'h01;
      @(negedge clk);
      start8 = 1'b0;
      wait8(4);
      @(negedge clk);
      chk("after_done_idle_busy", int'(busy8), 0);
      chk("after_done_single", int'(done8), 0);

      // Back-to-back: start held through DONE
      accept8(8'h7F, 8'h80, 1, 1'b1);
      wait8(8);
      a8   = 8'h44;
      b8   = 8'h22;
      bin8 = 1'b1;
      @(posedge clk);
      #1;
      q8.push_back(model(8, 8'h44, 8'h22, 1, cyc));
      start8 = 1'b0;
      wait8(8);

      // Reset mid-RUN at count=4
      accept8(8'hC3, 8'h15, 0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      q8.delete();
      #1;
      chk("midrst_busy", int'(busy8), 0);
      chk("midrst_done", int'(done8), 0);
      chk("midrst_diff", int'(diff8), 0);
      chk("midrst_borrow", int'(borrow8), 0);
      chk("midrst_ovf", int'(ovf8), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("midrst_no_restart", int'(busy8), 0);
      accept8(8'h5A, 8'hA5, 1, 1'b0); wait8(8);

      // Random WIDTH=8
      for (int i = 0; i < 40; i++) begin
         accept8(int'($urandom_range(255)), int'($urandom_range(255)),
                 int'($urandom_range(1)), 1'b0);
         wait8(8);
      end

      // Exhaustive WIDTH=2
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 2; c++)
               op2(a, b, c);

      repeat (3) @(negedge clk);
      chk("w8_queue_drained", q8.size(), 0);
      chk("w2_queue_drained", q2.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
